atmega_eep_sync: RTL and testbench

EEPROM persistence sequencer for the ATmega EEPROM peripheral. It drives the EEPROM's external access port (`ext_eep_*`). After reset it preloads the whole EEPROM image from an upstream byte stream. On request it streams the full image back out to a downstream byte sink, such as a flash or SPI writer. While either transfer runs it owns the EEPROM array and stalls CPU-side EEPROM register traffic.

---
 rtl/atmega_eep_sync.sv | 137 +++++++++++++
 tb/tb_atmega_eep_sync.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_eep_sync.sv
// EEPROM persistence sequencer: preloads the EEPROM image from an upstream byte
// stream after reset and streams it back out to a downstream sink on request.
module atmega_eep_sync #(
  parameter int unsigned EEP_SIZE      = 512,
  parameter bit          LOAD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic [7:0]  st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_last,
  input  logic        store_req,
  input  logic        content_modified,
  output logic [16:0] ext_eep_addr,
  output logic [7:0]  ext_eep_data_in,
  output logic        ext_eep_data_wr,
  output logic        ext_eep_data_rd,
  output logic        ext_eep_data_en,
  input  logic [7:0]  ext_eep_data_out,
  output logic        busy,
  output logic        cpu_stall,
  output logic        done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(EEP_SIZE - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_RD_ADDR,
    S_RD_CAP,
    S_SEND
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic               store_pend;
  logic               req_ok;

  assign req_ok    = store_req & content_modified;
  assign cpu_stall = busy;

  // LOAD writes go straight through in the handshake cycle; a reset cycle never writes.
  assign ext_eep_data_wr = ld_ready & ld_valid & rst;
  assign ext_eep_data_in = ext_eep_data_wr ? ld_data : DATA_W'(0);
  assign ext_eep_addr    = ld_ready ? ADDR_W'(cnt) : addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LOAD_ON_RESET ? S_LOAD : S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      store_pend <= 1'b0;
      ld_ready   <= 1'b0;
      st_data    <= '0;
      st_valid   <= 1'b0;
      st_last    <= 1'b0;
      ext_eep_data_rd <= 1'b0;
      ext_eep_data_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      // Requests seen while a transfer runs collapse into a single pending STORE.
      if (req_ok && state != S_IDLE) store_pend <= 1'b1;

      case (state)
        S_LOAD: begin
          if (!ld_ready) begin
            ld_ready        <= 1'b1;
            ext_eep_data_en <= 1'b1;
            busy            <= 1'b1;
          end else if (ld_valid) begin
            if (cnt == LAST_ADDR) begin
              cnt             <= '0;
              done            <= 1'b1;
              ld_ready        <= 1'b0;
              ext_eep_data_en <= 1'b0;
              busy            <= 1'b0;
              state           <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_IDLE: begin
          if (store_pend || req_ok) begin
            store_pend      <= 1'b0;
            addr_q          <= ADDR_W'(cnt);
            ext_eep_data_en <= 1'b1;
            ext_eep_data_rd <= 1'b1;
            busy            <= 1'b1;
            state           <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: state <= S_RD_CAP;
        S_RD_CAP: begin
          st_data         <= ext_eep_data_out;
          st_last         <= (cnt == LAST_ADDR);
          st_valid        <= 1'b1;
          ext_eep_data_rd <= 1'b0;
          state           <= S_SEND;
        end
        S_SEND: begin
          if (st_ready) begin
            st_valid <= 1'b0;
            st_last  <= 1'b0;
            if (st_last) begin
              cnt             <= '0;
              addr_q          <= '0;
              st_data         <= '0;
              done            <= 1'b1;
              ext_eep_data_en <= 1'b0;
              busy            <= 1'b0;
              state           <= S_IDLE;
            end else begin
              cnt             <= cnt + CNT_W'(1);
              addr_q          <= ADDR_W'(cnt + CNT_W'(1));
              ext_eep_data_rd <= 1'b1;
              state           <= S_RD_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_eep_sync.sv
// Directed bench for atmega_eep_sync: an 8-byte instance with LOAD on reset and a
// 512-byte instance starting in IDLE, each backed by a small EEPROM array model.
module tb_atmega_eep_sync;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 8-byte instance
  logic        rst, ld_valid, ld_ready, st_valid, st_ready, st_last;
  logic        store_req, content_modified, wr, rd, en, busy, cpu_stall, done;
  logic [7:0]  ld_data, st_data, data_in, rdata;
  logic [16:0] addr;

  // 512-byte instance
  logic        b_rst, b_ld_valid, b_ld_ready, b_st_valid, b_st_ready, b_st_last;
  logic        b_req, b_mod, b_wr, b_rd, b_en, b_busy, b_stall, b_done;
  logic [7:0]  b_ld_data, b_st_data, b_data_in, b_rdata;
  logic [16:0] b_addr;
  logic [16:0] b_max_addr  = '0;
  logic [16:0] b_last_addr = '0;

  logic [7:0]  mem   [8];
  logic [7:0]  b_mem [512];
  logic [24:0] wr_q[$];
  logic [8:0]  st_q[$];
  logic [8:0]  b_q[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  atmega_eep_sync #(.EEP_SIZE(8), .LOAD_ON_RESET(1'b1)) u_small (
    .clk(clk), .rst(rst), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_last(st_last),
    .store_req(store_req), .content_modified(content_modified),
    .ext_eep_addr(addr), .ext_eep_data_in(data_in), .ext_eep_data_wr(wr),
    .ext_eep_data_rd(rd), .ext_eep_data_en(en), .ext_eep_data_out(rdata),
    .busy(busy), .cpu_stall(cpu_stall), .done(done));

  atmega_eep_sync #(.EEP_SIZE(512), .LOAD_ON_RESET(1'b0)) u_big (
    .clk(clk), .rst(b_rst), .ld_data(b_ld_data), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .st_data(b_st_data), .st_valid(b_st_valid), .st_ready(b_st_ready), .st_last(b_st_last),
    .store_req(b_req), .content_modified(b_mod),
    .ext_eep_addr(b_addr), .ext_eep_data_in(b_data_in), .ext_eep_data_wr(b_wr),
    .ext_eep_data_rd(b_rd), .ext_eep_data_en(b_en), .ext_eep_data_out(b_rdata),
    .busy(b_busy), .cpu_stall(b_stall), .done(b_done));

  // EEPROM models and transaction logs
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr) wr_q.push_back({addr, data_in});
    if (st_valid && st_ready) begin
      st_q.push_back({st_last, st_data});
      hs_cyc.push_back(cyc);
    end
    if (en && wr) mem[addr[2:0]] <= data_in;
    if (en && rd) rdata <= mem[addr[2:0]];
    if (b_en && b_rd) b_rdata <= b_mem[b_addr[8:0]];
    if (b_en && b_addr > b_max_addr) b_max_addr <= b_addr;
    if (b_st_valid && b_st_ready) begin
      b_q.push_back({b_st_last, b_st_data});
      if (b_st_last) b_last_addr <= b_addr;
    end
  end

  task automatic do_load(input logic [7:0] base, input bit gap, input logic [7:0] req_mask);
    for (int i = 0; i < 8; i++) begin
      ld_data   = base + 8'(i);
      ld_valid  = 1'b1;
      store_req = req_mask[i];
      @(negedge clk);
      ld_valid  = 1'b0;
      store_req = 1'b0;
      if (gap && i < 7) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; b_rst = 1'b0;
    ld_data = '0; ld_valid = 1'b0; st_ready = 1'b0; store_req = 1'b0; content_modified = 1'b0;
    b_ld_data = '0; b_ld_valid = 1'b0; b_st_ready = 1'b0; b_req = 1'b0; b_mod = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ld_ready, busy, cpu_stall, done, st_valid, st_last, wr, rd, en} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {ld_ready, busy, cpu_stall, done, st_valid, st_last, wr, rd, en});
    end
    vectors++;
    if ({addr, st_data, data_in} !== 33'b0) begin
      miscompares++;
      $display("FAIL reset_data: addr %h st_data %h data_in %h want all 0", addr, st_data, data_in);
    end
    rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, cpu_stall, ld_ready, en} !== 4'b1111) begin
      miscompares++;
      $display("FAIL load_entry: got %b want 1111", {busy, cpu_stall, ld_ready, en});
    end
    vectors++;
    if ({b_busy, b_stall, b_ld_ready, b_en} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_entry_big: got %b want 0000", {b_busy, b_stall, b_ld_ready, b_en});
    end
  endtask

  task automatic test_load;
    wr_q.delete();
    do_load(8'h10, 1'b1, 8'h00);
    vectors++;
    if ({done, busy, ld_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL load_done: done/busy/ld_ready got %b want 100", {done, busy, ld_ready});
    end
    vectors++;
    if (wr_q.size() != 8) begin
      miscompares++;
      $display("FAIL load_wr_count: got %0d want 8", wr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wr_q[i] !== {17'(i), 8'h10 + 8'(i)}) begin
          miscompares++;
          $display("FAIL load_wr[%0d]: got %h want %h", i, wr_q[i], {17'(i), 8'h10 + 8'(i)});
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_not_modified;
    st_q.delete();
    content_modified = 1'b0;
    store_req = 1'b1;
    @(negedge clk);
    store_req = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({busy, en, rd, st_valid} !== 4'b0000 || st_q.size() != 0) begin
      miscompares++;
      $display("FAIL unmodified_req: busy/en/rd/st_valid got %b hs %0d want 0000 hs 0",
               {busy, en, rd, st_valid}, st_q.size());
    end
  endtask

  task automatic test_store_full;
    int start;
    st_q.delete(); hs_cyc.delete();
    content_modified = 1'b1;
    st_ready = 1'b1;
    store_req = 1'b1;
    @(negedge clk);
    store_req = 1'b0;
    start = cyc;
    vectors++;
    if ({busy, en, rd} !== 3'b111 || addr !== 17'd0) begin
      miscompares++;
      $display("FAIL rd_addr_entry: busy/en/rd got %b addr %h want 111 addr 0", {busy, en, rd}, addr);
    end
    for (int k = 0; k < 100 && st_q.size() < 8; k++) @(negedge clk);
    vectors++;
    if (st_q.size() != 8) begin
      miscompares++;
      $display("FAIL store_count: got %0d want 8", st_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (st_q[i] !== {1'(i == 7), 8'h10 + 8'(i)}) begin
          miscompares++;
          $display("FAIL store_byte[%0d]: got %h want %h", i, st_q[i], {1'(i == 7), 8'h10 + 8'(i)});
        end
      end
      vectors++;
      if (hs_cyc[7] - start != 23) begin
        miscompares++;
        $display("FAIL store_latency: got %0d want 23", hs_cyc[7] - start);
      end
      vectors++;
      if ({done, busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL store_done: done/busy got %b want 10", {done, busy});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random_ready;
    logic       pv, pr, pl;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    st_q.delete();
    st_ready = 1'b0;
    store_req = 1'b1;
    @(negedge clk);
    store_req = 1'b0;
    for (int k = 0; k < 400 && st_q.size() < 8; k++) begin
      if (pv && !pr) begin
        vectors++;
        if (st_valid !== 1'b1 || st_data !== pd || st_last !== pl) begin
          miscompares++;
          $display("FAIL stall_hold: valid/data/last got %b/%h/%b want 1/%h/%b",
                   st_valid, st_data, st_last, pd, pl);
        end
      end
      pv = st_valid; pd = st_data; pl = st_last;
      st_ready = 1'($urandom_range(0, 1));
      pr = st_ready;
      @(negedge clk);
    end
    st_ready = 1'b1;
    vectors++;
    if (st_q.size() != 8) begin
      miscompares++;
      $display("FAIL random_count: got %0d want 8", st_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (st_q[i] !== {1'(i == 7), 8'h10 + 8'(i)}) begin
          miscompares++;
          $display("FAIL random_byte[%0d]: got %h want %h", i, st_q[i], {1'(i == 7), 8'h10 + 8'(i)});
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      ld_data = 8'hA0 + 8'(i); ld_valid = 1'b1;
      @(negedge clk);
    end
    ld_data = 8'hA4;
    rst = 1'b0;
    @(negedge clk);
    ld_valid = 1'b0;
    vectors++;
    if (wr_q.size() != 4 || {ld_ready, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_abort: writes %0d ld_ready/busy %b want 4 00", wr_q.size(), {ld_ready, busy});
    end
    rst = 1'b1;
    @(negedge clk);
    wr_q.delete(); st_q.delete();
    content_modified = 1'b1;
    st_ready = 1'b1;
    do_load(8'hA0, 1'b0, 8'b0010_0100);
    vectors++;
    if (wr_q.size() != 8 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL reload: writes %0d done %b want 8 1", wr_q.size(), done);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wr_q[i] !== {17'(i), 8'hA0 + 8'(i)}) begin
          miscompares++;
          $display("FAIL reload_wr[%0d]: got %h want %h", i, wr_q[i], {17'(i), 8'hA0 + 8'(i)});
        end
      end
    end
    for (int k = 0; k < 100 && st_q.size() < 8; k++) @(negedge clk);
    repeat (30) @(negedge clk);
    vectors++;
    if (st_q.size() != 8 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pend_once: handshakes %0d busy %b want 8 0", st_q.size(), busy);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (st_q[i] !== {1'(i == 7), 8'hA0 + 8'(i)}) begin
          miscompares++;
          $display("FAIL pend_byte[%0d]: got %h want %h", i, st_q[i], {1'(i == 7), 8'hA0 + 8'(i)});
        end
      end
    end
  endtask

  task automatic test_big;
    for (int i = 0; i < 512; i++) b_mem[i] = 8'(i) ^ 8'h5A;
    b_q.delete();
    b_mod = 1'b1;
    b_st_ready = 1'b1;
    b_req = 1'b1;
    @(negedge clk);
    b_req = 1'b0;
    for (int k = 0; k < 2000 && b_q.size() < 512; k++) @(negedge clk);
    vectors++;
    if (b_q.size() != 512 || b_done !== 1'b1) begin
      miscompares++;
      $display("FAIL big_count: got %0d done %b want 512 1", b_q.size(), b_done);
    end else begin
      for (int i = 0; i < 512; i++) begin
        vectors++;
        if (b_q[i] !== {1'(i == 511), 8'(i) ^ 8'h5A}) begin
          miscompares++;
          $display("FAIL big_byte[%0d]: got %h want %h", i, b_q[i], {1'(i == 511), 8'(i) ^ 8'h5A});
        end
      end
    end
    vectors++;
    if (b_max_addr !== 17'h1FF || b_last_addr !== 17'h1FF) begin
      miscompares++;
      $display("FAIL big_addr: max %h last %h want 1ff 1ff", b_max_addr, b_last_addr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_not_modified();
    test_store_full();
    test_random_ready();
    test_reset_mid_load();
    test_big();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
